// File: rtl/bram16_arbiter.sv
// Two-port arbiter sharing one single-port 16-bit block RAM between fetch (m0) and load/store (m1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives m1 fixed priority.
module bram16_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [15:0] m0_a,
  input  logic [15:0] m0_do,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_di,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [15:0] m1_a,
  input  logic [15:0] m1_do,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_di,
  output logic        bram_we,
  output logic [15:0] bram_a,
  output logic [15:0] bram_do,
  input  logic [15:0] bram_di
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic        own_vld_q, own_vld_d;
  logic        own_id_q, own_id_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        pend0_q, pend0_d, pend1_q, pend1_d;
  logic [15:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [15:0] bram_a_q, bram_a_d, bram_do_q, bram_do_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;
`endif

  logic        owner_active;
  logic        gnt0, gnt1, any_gnt;
  logic        win_id, win_we, win_lock;
  logic [15:0] win_a, win_do;
  logic [7:0]  cnt_base, cnt_inc;

  always_comb begin
    owner_active = own_vld_q && (own_id_q ? m1_req : m0_req);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!sys_rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (owner_active) begin
      gnt0 = ~own_id_q;
      gnt1 = own_id_q;
    end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt0 = last_q;
      gnt1 = ~last_q;
`else
      gnt1 = 1'b1;
`endif
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end

    any_gnt  = gnt0 | gnt1;
    win_id   = gnt1;
    win_we   = gnt1 ? m1_we   : m0_we;
    win_lock = gnt1 ? m1_lock : m0_lock;
    win_a    = gnt1 ? m1_a    : m0_a;
    win_do   = gnt1 ? m1_do   : m0_do;

    // With no winner the RAM address/data buses keep their last driven values.
    bram_we   = any_gnt & win_we;
    bram_a    = any_gnt ? win_a  : bram_a_q;
    bram_do   = any_gnt ? win_do : bram_do_q;
    bram_a_d  = bram_a;
    bram_do_d = bram_do;

    // Any cycle without a locked grant releases ownership, including an owner dropping req.
    cnt_base   = (own_vld_q && (own_id_q == win_id)) ? lock_cnt_q : 8'd0;
    cnt_inc    = cnt_base + 8'd1;
    own_vld_d  = 1'b0;
    own_id_d   = 1'b0;
    lock_cnt_d = 8'd0;
    if (any_gnt && win_lock && (cnt_inc < LOCK_MAX_C)) begin
      own_vld_d  = 1'b1;
      own_id_d   = win_id;
      lock_cnt_d = cnt_inc;
    end

    pend0_d = gnt0 & ~m0_we;
    pend1_d = gnt1 & ~m1_we;
    hold0_d = pend0_q ? bram_di : hold0_q;
    hold1_d = pend1_q ? bram_di : hold1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = any_gnt ? win_id : last_q;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      own_vld_q  <= 1'b0;
      own_id_q   <= 1'b0;
      lock_cnt_q <= 8'd0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      hold0_q    <= 16'd0;
      hold1_q    <= 16'd0;
      bram_a_q   <= 16'd0;
      bram_do_q  <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      own_vld_q  <= own_vld_d;
      own_id_q   <= own_id_d;
      lock_cnt_q <= lock_cnt_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      bram_a_q   <= bram_a_d;
      bram_do_q  <= bram_do_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = pend0_q;
  assign m1_rvalid = pend1_q;
  assign m0_di     = pend0_q ? bram_di : hold0_q;
  assign m1_di     = pend1_q ? bram_di : hold1_q;

endmodule

// File: tb/tb_bram16_arbiter.sv
// Directed bench for bram16_arbiter with a behavioural RAM and per-port read-data scoreboards.
// Expectations follow ARB_ROUND_ROBIN_EN the same way the design does.
module tb_bram16_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_a, m0_do, m1_a, m1_do;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_di, m1_di;
  logic        bram_we;
  logic [15:0] bram_a, bram_do;
  logic [15:0] bram_di;

  logic [15:0] mem [256];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  bram16_arbiter #(.LOCK_MAX(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_a(m0_a), .m0_do(m0_do),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_di(m0_di),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_a(m1_a), .m1_do(m1_do),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_di(m1_di),
    .bram_we(bram_we), .bram_a(bram_a), .bram_do(bram_do), .bram_di(bram_di)
  );

  // Registered-read RAM; reset (re)loads the fixed test pattern.
  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'hAAAA;
      mem[8'h30] <= 16'h5555;
    end else if (bram_we) begin
      mem[bram_a[7:0]] <= bram_do;
    end
    bram_di <= mem[bram_a[7:0]];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("m0_unexpected_rvalid", 16'd1, 16'd0);
      else chk("m0_rdata", m0_di, q0.pop_front());
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("m1_unexpected_rvalid", 16'd1, 16'd0);
      else chk("m1_rdata", m1_di, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
  endtask

  initial begin
    logic e0;
    sys_rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_a = 0; m0_do = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_a = 0; m1_do = 0;
    tick(); tick();

    // reset: gnt forced low, all outputs cleared
    m0_req = 1; m0_a = 16'h0010;
    at_neg();
    chk("rst_gnt0", m0_gnt, 16'd0);
    tick();
    at_neg();
    chk("rst_rvalid0", m0_rvalid, 16'd0);
    chk("rst_rvalid1", m1_rvalid, 16'd0);
    chk("rst_di0", m0_di, 16'd0);
    chk("rst_di1", m1_di, 16'd0);
    chk("rst_bram_we", bram_we, 16'd0);
    chk("rst_bram_a", bram_a, 16'd0);
    chk("rst_bram_do", bram_do, 16'd0);
    tick();
    sys_rst = 1'b1;

    // single read
    at_neg();
    chk("rd_gnt0", m0_gnt, 16'd1);
    chk("rd_gnt1", m1_gnt, 16'd0);
    chk("rd_bram_a", bram_a, 16'h0010);
    chk("rd_bram_we", bram_we, 16'd0);
    q0.push_back(16'hBEEF);
    tick();
    m0_req = 0;
    at_neg();
    chk("rd_rvalid", m0_rvalid, 16'd1);
    chk("idle_bram_a_hold", bram_a, 16'h0010);
    tick();
    at_neg();
    chk("rd_rvalid_pulse", m0_rvalid, 16'd0);
    chk("rd_hold", m0_di, 16'hBEEF);

    // write then read
    tick();
    m1_req = 1; m1_we = 1; m1_a = 16'h0005; m1_do = 16'h1234;
    at_neg();
    chk("wr_gnt1", m1_gnt, 16'd1);
    chk("wr_bram_we", bram_we, 16'd1);
    chk("wr_bram_do", bram_do, 16'h1234);
    tick();
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_a = 16'h0005;
    at_neg();
    chk("wr_no_rvalid", m1_rvalid, 16'd0);
    chk("wr_rd_gnt0", m0_gnt, 16'd1);
    q0.push_back(16'h1234);
    tick();
    m0_req = 0;
    at_neg();
    chk("wr_rd_rvalid", m0_rvalid, 16'd1);
    chk("wr_rd_data", m0_di, 16'h1234);

    // contention: both read continuously
    tick();
    m0_req = 1; m0_a = 16'h0020;
    m1_req = 1; m1_a = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      e0 = RR && (i % 2 == 1);
      chk($sformatf("cont%0d_gnt0", i), m0_gnt, 16'(e0));
      chk($sformatf("cont%0d_gnt1", i), m1_gnt, 16'(!e0));
      if (e0) q0.push_back(16'hAAAA);
      else q1.push_back(16'h5555);
      tick();
    end
    m0_req = 0; m1_req = 0;
    tick();

    // lock: m0 holds for LOCK_MAX=3 grants against m1
    m0_req = 1; m0_lock = 1; m0_a = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("lock%0d_gnt0", i), m0_gnt, 16'd1);
      chk($sformatf("lock%0d_gnt1", i), m1_gnt, 16'd0);
      q0.push_back(16'hAAAA);
      tick();
      m1_req = 1; m1_a = 16'h0030;
    end
    at_neg();
    chk("lock_rel_gnt1", m1_gnt, 16'd1);
    chk("lock_rel_gnt0", m0_gnt, 16'd0);
    q1.push_back(16'h5555);
    tick();
    m0_req = 0; m0_lock = 0; m1_req = 0;
    tick();

    // lock variant: owner drops req, other port granted in the same cycle
    m0_req = 1; m0_lock = 1;
    at_neg();
    chk("lockv_gnt0", m0_gnt, 16'd1);
    q0.push_back(16'hAAAA);
    tick();
    m0_req = 0; m0_lock = 0; m1_req = 1;
    at_neg();
    chk("lockv_drop_gnt1", m1_gnt, 16'd1);
    chk("lockv_drop_gnt0", m0_gnt, 16'd0);
    q1.push_back(16'h5555);
    tick();
    m0_req = 1;
    at_neg();
    chk("lockv_after_gnt0", m0_gnt, 16'(RR));
    chk("lockv_after_gnt1", m1_gnt, 16'(!RR));
    if (RR) q0.push_back(16'hAAAA);
    else q1.push_back(16'h5555);
    tick();
    m0_req = 0; m1_req = 0;
    tick();

    // reset while a granted read is in flight
    m0_req = 1; m0_a = 16'h0010;
    at_neg();
    chk("rstrd_gnt0", m0_gnt, 16'd1);
    #1;
    sys_rst = 1'b0;
    tick();
    m0_req = 0;
    at_neg();
    chk("rstrd_rvalid", m0_rvalid, 16'd0);
    chk("rstrd_di0", m0_di, 16'd0);
    chk("rstrd_di1", m1_di, 16'd0);
    tick();
    sys_rst = 1'b1;
    m0_req = 1; m0_a = 16'h0020;
    m1_req = 1; m1_a = 16'h0030;
    at_neg();
    chk("post_rst_gnt0", m0_gnt, 16'(RR));
    chk("post_rst_gnt1", m1_gnt, 16'(!RR));
    if (RR) q0.push_back(16'hAAAA);
    else q1.push_back(16'h5555);
    tick();
    m0_req = 0; m1_req = 0;
    tick(); tick();
    at_neg();
    chk("q0_drained", 16'(q0.size()), 16'd0);
    chk("q1_drained", 16'(q1.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram16_arbiter.md
# bram16_arbiter

Two-requester arbiter sharing one single-port 16-bit block RAM (bram16) between the instruction-fetch port (m0) and the data load/store port (m1) of the processor. At most one access is issued to the RAM per clock. Read data returns on the requesting port one cycle after the grant and is held per port until that port's next read completes. A bounded lock supports atomic multi-cycle sequences such as read-modify-write.

## Interface
Parameters:
- LOCK_MAX, 8: maximum consecutive grants a port may hold under lock before forced release; range 1–255.

Ports:
- sys_clk  in  1  single clock; all state updates on rising edge.
- sys_rst  in  1  reset, synchronous, active-low.
- m0_req, m1_req  in  1  access request; held with fields stable until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  keep ownership after this grant.
- m0_a, m1_a  in  16  word address, passed unmodified to the RAM.
- m0_do, m1_do  in  16  write data.
- m0_gnt, m1_gnt  out  1  access accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid this cycle (one-cycle pulse).
- m0_di, m1_di  out  16  read data.
- bram_we  out  1  RAM write enable.
- bram_a  out  16  RAM address.
- bram_do  out  16  RAM write data.
- bram_di  in  16  RAM registered read data.

## Operation
- Each cycle, select the winner among requesting ports:
  - If a port owns the lock, it wins whenever it requests; the other port is blocked.
  - Otherwise the priority rule applies (see Configuration).
- The winner's gnt=1. Its we, a and do drive bram_we, bram_a and bram_do.
- With no winner: bram_we=0; bram_a and bram_do hold their last driven values.
- A port with req=0 is never granted.
- Lock, per grant with lock=1:
  - The port becomes or stays owner; lock_cnt increments.
  - When lock_cnt reaches LOCK_MAX, ownership is released after that grant. The port must win normal arbitration to continue.
- Lock is released by either:
  - a grant with lock=0, or
  - a cycle in which the owner has req=0.
- On release, lock_cnt clears.
- Reads return data as follows:
  - A granted read sets a per-port pending flag at the edge.
  - The next cycle, that port has rvalid=1 and mN_di=bram_di.
  - At the end of that cycle, bram_di is captured into the port's hold register.
  - In all other cycles mN_di = hold register.
- Writes produce no rvalid. The write data is visible to a read granted on the next cycle.
- Round-robin pointer last, when compiled in: records the most recently granted port; updates on every grant.

## Timing
- Grant latency: zero cycles. The RAM samples the winner's fields at the edge ending the grant cycle.
- Read latency: rvalid and data appear in the cycle after gnt. Back-to-back reads from one port give consecutive rvalid pulses.
- Simultaneous requests, no lock: exactly one gnt. The loser keeps req and is re-arbitrated next cycle.
- Lock owner with req=0 in one cycle: lock released in that same cycle, and the other port may be granted in that cycle.
- Reset (sys_rst=0 at an edge):
  - gnt=0 and rvalid=0 (rvalid is cleared even if a read was in flight).
  - m0_di=m1_di=0; lock owner and lock_cnt cleared; last=m1.
  - bram_we=0; bram_a=0; bram_do=0.
  - During reset cycles, gnt is forced to 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined: with no lock owner and both requesting, the port not in last wins, so m0 wins first after reset.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, m1 (data) always beats m0. The last register is not implemented.

## Test plan
- Single read: preload addr 0x0010=0xBEEF; m0 reads 0x0010 → m0_gnt in cycle T; m0_rvalid=1 and m0_di=0xBEEF in T+1; m0_di stays 0xBEEF afterwards.
- Contention: both ports read continuously.
  - With ARB_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1, …
  - Without it: m1 is granted every cycle and m0 never.
- Write-then-read: m1 writes 0x1234 to 0x0005 in T; m0 reads 0x0005 in T+1 → m0_di=0x1234 in T+2; no rvalid for the write.
- Lock: m1 holds lock=1 with m0 requesting, LOCK_MAX=3 → m1 granted 3 cycles, then m0 granted (RR on). A variant drops m1_req after 1 grant → m0 granted in that same cycle.
- Reset mid-read: assert sys_rst=0 on the edge after a granted read → no rvalid; m0_di=m1_di=0; after release, the first simultaneous request grants m0 (RR on).
